// File: rtl/prince_dec_iter.sv
// -----------------------------------------------------------------------------
// prince_dec_iter
//
// Iterative PRINCE block cipher core, decryption direction. One PRINCE round
// is evaluated per clock; a block takes 11 cycles from acceptance to result.
// Decryption reuses the encryption round structure through the
// alpha-reflection property:
//   whitening in  = k0' = (k0 >>> 1) ^ (k0 >> 63)
//   whitening out = k0
//   round key     = k1 ^ alpha
//
// Configuration:
//   ZERO_OUT_IDLE (parameter, default 1): data_out reads 0 while out_valid is
//     low; with 0 it shows the internal state register at all times.
//   PRINCE_ENC_EN (macro, default undefined): adds a 'mode' input sampled at
//     acceptance. mode=1 encrypts (whitening in k0, out k0', round key k1),
//     mode=0 decrypts as above. Without the macro the core only decrypts.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   ciphertext and key present on data_in / key_in
//   in_ready   core can accept (high only in IDLE)
//   data_in    64-bit ciphertext
//   key_in     128-bit key, k0 = key_in[127:64], k1 = key_in[63:0]
//   mode       (PRINCE_ENC_EN only) 1 = encrypt, 0 = decrypt
//   out_valid  plaintext valid, held until out_ready
//   out_ready  consumer accepts plaintext
//   data_out   64-bit plaintext
// -----------------------------------------------------------------------------
module prince_dec_iter #(
   parameter bit ZERO_OUT_IDLE = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   data_in,
   input  logic [127:0]  key_in,
`ifdef PRINCE_ENC_EN
   input  logic          mode,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   data_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_e;

   localparam logic [63:0] ALPHA      = 64'hc0ac29b7c97c50dd;
   localparam logic [3:0]  LAST_ROUND = 4'd11;

   localparam logic [3:0] SBOX [16] = '{
      4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
      4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
   };
   localparam logic [3:0] SBOX_INV [16] = '{
      4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
      4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
   };

   // Nibble n (n = 0 at [63:60]) of the SR output takes input nibble SR_IDX[n].
   // The state is column-major: nibble 4*col + row, row r rotated left by r.
   localparam int SR_IDX [16] = '{
      0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11
   };
   localparam int SR_INV_IDX [16] = '{
      0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3
   };

   // -------------------------------------------------------------------------
   // Round primitives
   // -------------------------------------------------------------------------
   function automatic logic [63:0] sub_nib(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      for (int n = 0; n < 16; n++)
         y[4*n +: 4] = inv ? SBOX_INV[x[4*n +: 4]] : SBOX[x[4*n +: 4]];
      return y;
   endfunction

   function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      for (int n = 0; n < 16; n++)
         y[63 - 4*n -: 4] = inv ? x[63 - 4*SR_INV_IDX[n] -: 4] : x[63 - 4*SR_IDX[n] -: 4];
      return y;
   endfunction

   // M' = diag(M^0, M^1, M^1, M^0) over 16-bit chunks, MSB chunk first.
   // Inside a chunk, block (row r, col c) of M^k is the 4x4 identity with bit
   // (r + c + k) mod 4 cleared, bits counted from the nibble MSB.
   function automatic logic [63:0] m_prime(input logic [63:0] x);
      logic [63:0] y;
      int          k;
      y = '0;
      for (int h = 0; h < 4; h++) begin
         k = (h == 0 || h == 3) ? 0 : 1;
         for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
               for (int c = 0; c < 4; c++)
                  if (((r + c + k) % 4) != b)
                     y[63 - 16*h - 4*r - b] ^= x[63 - 16*h - 4*c - b];
      end
      return y;
   endfunction

   function automatic logic [63:0] round_const(input logic [3:0] idx);
      logic [63:0] rc;
      case (idx)
         4'd1:    rc = 64'h13198a2e03707344;
         4'd2:    rc = 64'ha4093822299f31d0;
         4'd3:    rc = 64'h082efa98ec4e6c89;
         4'd4:    rc = 64'h452821e638d01377;
         4'd5:    rc = 64'hbe5466cf34e90c6c;
         4'd6:    rc = 64'h7ef84f78fd955cb1;
         4'd7:    rc = 64'h85840851f1ac43aa;
         4'd8:    rc = 64'hc882d32f25323c54;
         4'd9:    rc = 64'h64a51195e0e3610d;
         4'd10:   rc = 64'hd3b5a399ca0c2399;
         4'd11:   rc = 64'hc0ac29b7c97c50dd;
         default: rc = 64'h0;
      endcase
      return rc;
   endfunction

   // One iteration for counter value c: forward rounds 1..5, the keyless
   // middle layer at 6, inverse rounds i = c-1 at 7..11. The last iteration
   // also folds in the output whitening.
   function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [3:0] c,
                                            input logic [63:0] kr, input logic [63:0] kout);
      logic [63:0] r;
      if (c >= 4'd1 && c <= 4'd5) begin
         r = shift_rows(m_prime(sub_nib(s, 1'b0)), 1'b0) ^ round_const(c) ^ kr;
      end else if (c == 4'd6) begin
         r = sub_nib(m_prime(sub_nib(s, 1'b0)), 1'b1);
      end else if (c >= 4'd7 && c <= LAST_ROUND) begin
         r = sub_nib(m_prime(shift_rows(s ^ round_const(c - 4'd1) ^ kr, 1'b1)), 1'b1);
         if (c == LAST_ROUND)
            r = r ^ round_const(LAST_ROUND) ^ kr ^ kout;
      end else begin
         r = s;
      end
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // Key schedule at acceptance
   // -------------------------------------------------------------------------
   logic [63:0] k0, k1, k0_prime;
   logic [63:0] k_white_in, k_white_out, k_round;

   assign k0       = key_in[127:64];
   assign k1       = key_in[63:0];
   assign k0_prime = {k0[0], k0[63:1]} ^ (k0 >> 63);

`ifdef PRINCE_ENC_EN
   assign k_white_in  = mode ? k0       : k0_prime;
   assign k_white_out = mode ? k0_prime : k0;
   assign k_round     = mode ? k1       : (k1 ^ ALPHA);
`else
   assign k_white_in  = k0_prime;
   assign k_white_out = k0;
   assign k_round     = k1 ^ ALPHA;
`endif

   // -------------------------------------------------------------------------
   // Control and datapath
   // -------------------------------------------------------------------------
   fsm_e        fsm_q, fsm_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] state_q, state_d;
   logic [63:0] kr_q, kr_d;
   logic [63:0] kout_q, kout_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      fsm_d       = fsm_q;
      cnt_d       = cnt_q;
      state_d     = state_q;
      kr_d        = kr_q;
      kout_d      = kout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (fsm_q)
         IDLE: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            if (in_valid) begin
               state_d    = data_in ^ k_white_in ^ k_round;
               kr_d       = k_round;
               kout_d     = k_white_out;
               cnt_d      = 4'd1;
               fsm_d      = BUSY;
               in_ready_d = 1'b0;
            end
         end
         BUSY: begin
            state_d = round_fn(state_q, cnt_q, kr_q, kout_q);
            // >= rather than == so a corrupted counter can never run past 11.
            if (cnt_q >= LAST_ROUND) begin
               cnt_d       = '0;
               fsm_d       = DONE;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d       = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            fsm_d       = IDLE;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the key and state registers are reset along with control so
         // a reset mid-block leaves no trace of the key or the partial result.
         fsm_q       <= IDLE;
         cnt_q       <= '0;
         state_q     <= '0;
         kr_q        <= '0;
         kout_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         fsm_q       <= fsm_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         kr_q        <= kr_d;
         kout_q      <= kout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = (ZERO_OUT_IDLE && !out_valid_q) ? 64'h0 : state_q;

endmodule
